screen_sequencer: RTL and testbench
===================================

Name: screen_sequencer

Overview:
- Frame-synchronous controller that decides which text overlays are shown (title, how-to, HUD, game-over) and sequences the game between screens.
- Sits between the synchronized button inputs and game logic on one side, and the text renderer and colour mux on the other.
- Drives layer enables, a menu cursor with blink, a one-cycle game reset pulse, and the latched final score.
- Screen changes occur only at frame boundaries, so no frame shows a partial overlay.

Parameters:
- BLINK_FRAMES, 30, frame ticks per blink half-period of the selected menu item.
- HOWTO_TIMEOUT_FRAMES, 600, frame ticks before the how-to screen returns to title on its own.
- GAMEOVER_HOLD_FRAMES, 120, frame ticks during which presses are ignored on the game-over screen.
- SCORE_W, 10, score width in bits.

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse, once per frame at vblank start.
- btn_start  in  1  synchronized start/confirm button level.
- btn_select  in  1  synchronized menu-select button level.
- hp_zero  in  1  level from game logic: player HP exhausted.
- score_in  in  SCORE_W  live score.
- state  out  2  0=TITLE, 1=HOWTO, 2=PLAY, 3=OVER.
- title_en  out  1  title overlay enable.
- howto_en  out  1  instruction overlay enable.
- hud_en  out  1  SCORE/HP HUD enable.
- gameover_en  out  1  game-over overlay enable.
- select_idx  out  1  menu cursor: 0=START, 1=HOW TO PLAY.
- sel_blink_on  out  1  visibility of the selected menu item.
- game_run  out  1  high while in PLAY.
- game_reset  out  1  one-cycle pulse on entry to PLAY.
- final_score  out  SCORE_W  score captured at game over.

Behaviour:
- Reset (async, rst_n=0):
  - state=TITLE, title_en=1, all other enables 0.
  - select_idx=0, sel_blink_on=1, game_run=0, game_reset=0, final_score=0.
  - All pending flags and counters 0.
- All outputs are registered. Enables, game_run and state are a decode of the state register.
- Edge detection:
  - The previous level of each button is registered. A rising edge at cycle n sets start_pend / select_pend at n+1.
  - An edge arriving in the same cycle as frame_tick is not consumed by that tick; it is consumed at the next tick.
- Transitions are evaluated only on frame_tick cycles, and the new state is visible the following cycle. On every frame_tick both pending flags are cleared, whether consumed or not.
- Frame counter:
  - Counts frame_ticks, is cleared on every state change, and saturates at its maximum.
  - Width is enough to hold the largest parameter.
- TITLE:
  - Counter wraps at BLINK_FRAMES-1 and toggles sel_blink_on on wrap.
  - select_pend alone: toggle select_idx, set sel_blink_on=1, clear counter.
  - start_pend with select_idx=0: go to PLAY. start_pend with select_idx=1: go to HOWTO.
  - start_pend and select_pend together: start wins, select is discarded, and the current select_idx is used.
- HOWTO:
  - start_pend, or counter reaching HOWTO_TIMEOUT_FRAMES-1 → TITLE.
  - select_pend is ignored.
- PLAY:
  - hp_zero=1 on a tick → OVER, with final_score <= score_in in that same cycle.
  - Presses are ignored.
- OVER:
  - Presses are ignored while counter < GAMEOVER_HOLD_FRAMES; pending flags latched during the hold are discarded at each tick.
  - After the hold, start_pend → TITLE.
  - final_score holds until the next capture; it is not cleared on TITLE.
- Entry to TITLE sets select_idx=0, sel_blink_on=1, counter=0.
- game_reset is high for exactly the first cycle in PLAY (the cycle after the transition tick), never otherwise.
- Reset mid-operation: immediate return to reset values. No game_reset pulse is generated by reset.

Test Plan:
- Reset: release rst_n, 3 ticks with no buttons → state=0, title_en=1, select_idx=0; sel_blink_on=1 until tick 30, then 0 from the cycle after tick 30.
- Select then start: select edge, tick (select_idx→1), start edge, tick → state=1, howto_en=1; 600 further ticks with no press → state=0, select_idx=0.
- Start+select pending together at select_idx=0, tick → state=2, game_reset high one cycle only, select_idx stays 0.
- PLAY with score_in=357, hp_zero=1 at a tick → state=3, final_score=357; score_in changing afterwards leaves it at 357.
- OVER: start edges at ticks 10 and 119 → remain OVER; start edge after tick 120, next tick → state=0, final_score still 357.
- Start edge coincident with frame_tick in TITLE → no change at that tick, PLAY after the next tick; assert rst_n=0 mid-PLAY → outputs at reset values within the same cycle, no game_reset.

Source files
------------

// File: rtl/screen_sequencer.sv
// screen_sequencer: frame-synchronous screen/overlay controller.
// Picks which text layers are visible (title, how-to, HUD, game-over),
// runs the title menu cursor with blink, pulses game_reset on entry to
// PLAY and latches the final score. State only changes on frame_tick so
// every frame shows a complete overlay.
module screen_sequencer #(
   parameter int BLINK_FRAMES         = 30,
   parameter int HOWTO_TIMEOUT_FRAMES = 600,
   parameter int GAMEOVER_HOLD_FRAMES = 120,
   parameter int SCORE_W              = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               btn_start,
   input  logic               btn_select,
   input  logic               hp_zero,
   input  logic [SCORE_W-1:0] score_in,
   output logic [1:0]         state,
   output logic               title_en,
   output logic               howto_en,
   output logic               hud_en,
   output logic               gameover_en,
   output logic               select_idx,
   output logic               sel_blink_on,
   output logic               game_run,
   output logic               game_reset,
   output logic [SCORE_W-1:0] final_score
);

   // Frame counter must hold the largest of the frame-count parameters.
   localparam int MAX_A      = (BLINK_FRAMES > HOWTO_TIMEOUT_FRAMES) ?
                               BLINK_FRAMES : HOWTO_TIMEOUT_FRAMES;
   localparam int MAX_FRAMES = (MAX_A > GAMEOVER_HOLD_FRAMES) ?
                               MAX_A : GAMEOVER_HOLD_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [CNT_W-1:0] HOWTO_LAST = CNT_W'(HOWTO_TIMEOUT_FRAMES - 1);
   localparam logic [CNT_W-1:0] HOLD_CNT   = CNT_W'(GAMEOVER_HOLD_FRAMES);

   typedef enum logic [1:0] {
      S_TITLE = 2'd0,
      S_HOWTO = 2'd1,
      S_PLAY  = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               sel_reg, sel_next;
   logic               blink_reg, blink_next;
   logic               start_pend_reg, start_pend_next;
   logic               select_pend_reg, select_pend_next;
   logic               prev_start_reg, prev_select_reg;
   logic [SCORE_W-1:0] final_reg, final_next;
   logic               game_reset_reg, game_reset_next;
   logic               title_en_reg, howto_en_reg, hud_en_reg, gameover_en_reg;
   logic               game_run_reg;
   logic               start_edge, select_edge;
   logic [CNT_W-1:0]   cnt_inc;

   assign start_edge  = btn_start  & ~prev_start_reg;
   assign select_edge = btn_select & ~prev_select_reg;
   assign cnt_inc     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

   // Next-state, counter, cursor and capture logic; decisions only on frame_tick.
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      sel_next        = sel_reg;
      blink_next      = blink_reg;
      final_next      = final_reg;
      game_reset_next = 1'b0;
      // A new edge survives the tick it coincides with; everything else
      // pending is dropped on every tick whether it was used or not.
      start_pend_next  = start_edge  | (start_pend_reg  & ~frame_tick);
      select_pend_next = select_edge | (select_pend_reg & ~frame_tick);

      if (frame_tick) begin
         case (state_reg)
            S_TITLE: begin
               if (start_pend_reg) begin
                  state_next = sel_reg ? S_HOWTO : S_PLAY;
               end else if (select_pend_reg) begin
                  sel_next   = ~sel_reg;
                  blink_next = 1'b1;
                  cnt_next   = '0;
               end else if (cnt_reg == BLINK_LAST) begin
                  cnt_next   = '0;
                  blink_next = ~blink_reg;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
            S_HOWTO: begin
               if (start_pend_reg || (cnt_reg == HOWTO_LAST)) begin
                  state_next = S_TITLE;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
            S_PLAY: begin
               if (hp_zero) begin
                  state_next = S_OVER;
                  final_next = score_in;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
            default: begin
               if (start_pend_reg && (cnt_reg >= HOLD_CNT)) begin
                  state_next = S_TITLE;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         endcase

         if (state_next != state_reg) begin
            cnt_next = '0;
            if (state_next == S_TITLE) begin
               sel_next   = 1'b0;
               blink_next = 1'b1;
            end
            if (state_next == S_PLAY) begin
               game_reset_next = 1'b1;
            end
         end
      end
   end

   // State, counters, flags and registered output decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_TITLE;
         cnt_reg         <= '0;
         sel_reg         <= 1'b0;
         blink_reg       <= 1'b1;
         start_pend_reg  <= 1'b0;
         select_pend_reg <= 1'b0;
         prev_start_reg  <= 1'b0;
         prev_select_reg <= 1'b0;
         final_reg       <= '0;
         game_reset_reg  <= 1'b0;
         title_en_reg    <= 1'b1;
         howto_en_reg    <= 1'b0;
         hud_en_reg      <= 1'b0;
         gameover_en_reg <= 1'b0;
         game_run_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         sel_reg         <= sel_next;
         blink_reg       <= blink_next;
         start_pend_reg  <= start_pend_next;
         select_pend_reg <= select_pend_next;
         prev_start_reg  <= btn_start;
         prev_select_reg <= btn_select;
         final_reg       <= final_next;
         game_reset_reg  <= game_reset_next;
         title_en_reg    <= (state_next == S_TITLE);
         howto_en_reg    <= (state_next == S_HOWTO);
         hud_en_reg      <= (state_next == S_PLAY);
         gameover_en_reg <= (state_next == S_OVER);
         game_run_reg    <= (state_next == S_PLAY);
      end
   end

   assign state        = state_reg;
   assign title_en     = title_en_reg;
   assign howto_en     = howto_en_reg;
   assign hud_en       = hud_en_reg;
   assign gameover_en  = gameover_en_reg;
   assign select_idx   = sel_reg;
   assign sel_blink_on = blink_reg;
   assign game_run     = game_run_reg;
   assign game_reset   = game_reset_reg;
   assign final_score  = final_reg;

endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed scenarios followed by randomized stimulus,
// every cycle compared against a behavioural screen model.
module tb_screen_sequencer;

   localparam int BLINK   = 30;
   localparam int TIMEOUT = 600;
   localparam int HOLD    = 120;
   localparam int SW      = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          frame_tick;
   logic          btn_start;
   logic          btn_select;
   logic          hp_zero;
   logic [SW-1:0] score_in;
   logic [1:0]    state;
   logic          title_en, howto_en, hud_en, gameover_en;
   logic          select_idx, sel_blink_on, game_run, game_reset;
   logic [SW-1:0] final_score;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: screen, ticks seen since the screen (or cursor) last
   // restarted, pending presses, captured score.
   int m_state, m_ticks, m_final;
   bit m_sel, m_blink, m_reset_pulse;
   bit m_start_pend, m_select_pend, m_prev_start, m_prev_select;

   screen_sequencer #(
      .BLINK_FRAMES(BLINK), .HOWTO_TIMEOUT_FRAMES(TIMEOUT),
      .GAMEOVER_HOLD_FRAMES(HOLD), .SCORE_W(SW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
      .btn_start(btn_start), .btn_select(btn_select), .hp_zero(hp_zero),
      .score_in(score_in), .state(state), .title_en(title_en),
      .howto_en(howto_en), .hud_en(hud_en), .gameover_en(gameover_en),
      .select_idx(select_idx), .sel_blink_on(sel_blink_on),
      .game_run(game_run), .game_reset(game_reset), .final_score(final_score)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_ticks = 0; m_final = 0;
      m_sel = 0; m_blink = 1; m_reset_pulse = 0;
      m_start_pend = 0; m_select_pend = 0; m_prev_start = 0; m_prev_select = 0;
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_clock();
      int nxt;
      bit s_edge, l_edge;
      if (!rst_n) begin
         model_reset();
         return;
      end
      s_edge = btn_start && !m_prev_start;
      l_edge = btn_select && !m_prev_select;
      m_reset_pulse = 0;
      nxt = m_state;
      if (frame_tick) begin
         case (m_state)
            0: begin
               if (m_start_pend) nxt = m_sel ? 1 : 2;
               else if (m_select_pend) begin
                  m_sel = !m_sel; m_ticks = 0; m_blink = 1;
               end else begin
                  m_ticks++;
                  m_blink = ((m_ticks / BLINK) % 2) == 0;
               end
            end
            1: begin
               if (m_start_pend || (m_ticks + 1 == TIMEOUT)) nxt = 0;
               else m_ticks++;
            end
            2: begin
               if (hp_zero) begin nxt = 3; m_final = int'(score_in); end
               else m_ticks++;
            end
            default: begin
               if (m_start_pend && m_ticks >= HOLD) nxt = 0;
               else m_ticks++;
            end
         endcase
         if (nxt != m_state) begin
            m_ticks = 0;
            if (nxt == 0) begin m_sel = 0; m_blink = 1; end
            if (nxt == 2) m_reset_pulse = 1;
            $display("screen %0d -> %0d at %0t (score %0d)", m_state, nxt, $time, m_final);
         end
         m_state = nxt;
      end
      m_start_pend  = s_edge || (m_start_pend && !frame_tick);
      m_select_pend = l_edge || (m_select_pend && !frame_tick);
      m_prev_start  = btn_start;
      m_prev_select = btn_select;
   endtask

   function automatic logic [31:0] dut_vec();
      return {10'd0, state, title_en, howto_en, hud_en, gameover_en,
              select_idx, sel_blink_on, game_run, game_reset, final_score};
   endfunction

   function automatic logic [31:0] model_vec();
      return {10'd0, 2'(m_state), m_state == 0, m_state == 1, m_state == 2, m_state == 3,
              m_sel, m_blink, m_state == 2, m_reset_pulse, SW'(m_final)};
   endfunction

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic step();
      @(posedge clk);
      model_clock();
      @(negedge clk);
      check("outs", dut_vec(), model_vec());
   endtask

   task automatic do_tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (3) step();
   endtask

   task automatic press_start();
      btn_start = 1'b1; step(); btn_start = 1'b0; step();
   endtask

   task automatic press_select();
      btn_select = 1'b1; step(); btn_select = 1'b0; step();
   endtask

   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; btn_start = 1'b0; btn_select = 1'b0;
      hp_zero = 1'b0; score_in = '0;
      model_reset();
      repeat (3) step();
      check("rst_state", 32'(state), 32'd0);
      check("rst_title", 32'(title_en), 32'd1);
      check("rst_blink", 32'(sel_blink_on), 32'd1);
      check("rst_final", 32'(final_score), 32'd0);
      check("rst_greset", 32'(game_reset), 32'd0);
      rst_n = 1'b1;

      // Idle title: blink stays on through tick 29, drops after tick 30.
      repeat (3) do_tick();
      check("idle_state", 32'(state), 32'd0);
      check("idle_sel", 32'(select_idx), 32'd0);
      repeat (26) do_tick();
      check("blink_29", 32'(sel_blink_on), 32'd1);
      do_tick();
      check("blink_30", 32'(sel_blink_on), 32'd0);

      // Select moves the cursor, start enters how-to, timeout returns.
      press_select();
      do_tick();
      check("sel_toggle", 32'(select_idx), 32'd1);
      check("sel_blink", 32'(sel_blink_on), 32'd1);
      press_start();
      do_tick();
      check("howto_state", 32'(state), 32'd1);
      check("howto_en", 32'(howto_en), 32'd1);
      repeat (TIMEOUT - 1) do_tick();
      check("howto_599", 32'(state), 32'd1);
      do_tick();
      check("howto_to", 32'(state), 32'd0);
      check("howto_sel", 32'(select_idx), 32'd0);

      // Start and select pending together: start wins with cursor 0.
      btn_start = 1'b1; btn_select = 1'b1; step();
      btn_start = 1'b0; btn_select = 1'b0; step();
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      check("both_state", 32'(state), 32'd2);
      check("both_greset", 32'(game_reset), 32'd1);
      check("both_sel", 32'(select_idx), 32'd0);
      step();
      check("greset_once", 32'(game_reset), 32'd0);
      repeat (5) do_tick();

      // Game over captures the live score, later score changes ignored.
      score_in = 10'd357; hp_zero = 1'b1;
      do_tick();
      hp_zero = 1'b0; score_in = 10'd12;
      check("over_state", 32'(state), 32'd3);
      check("over_final", 32'(final_score), 32'd357);
      step();
      for (int t = 1; t <= HOLD; t++) begin
         frame_tick = 1'b1;
         btn_start = (t == 10 || t == HOLD - 1);
         step();
         frame_tick = 1'b0; btn_start = 1'b0;
         repeat (3) step();
      end
      check("over_hold", 32'(state), 32'd3);
      check("over_keep", 32'(final_score), 32'd357);
      press_start();
      do_tick();
      check("over_exit", 32'(state), 32'd0);
      check("over_final2", 32'(final_score), 32'd357);

      // Start edge coincident with a tick is deferred by one frame.
      frame_tick = 1'b1; btn_start = 1'b1; step();
      frame_tick = 1'b0; btn_start = 1'b0;
      check("coinc_hold", 32'(state), 32'd0);
      repeat (3) step();
      do_tick();
      check("coinc_play", 32'(state), 32'd2);
      repeat (3) step();

      // Asynchronous reset mid-play takes effect before the next edge.
      @(posedge clk);
      model_clock();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_vec", dut_vec(), model_vec());
      check("arst_state", 32'(state), 32'd0);
      check("arst_greset", 32'(game_reset), 32'd0);
      @(negedge clk);
      step();
      rst_n = 1'b1;
      repeat (4) step();

      // Randomized phase.
      for (int c = 0; c < 15000; c++) begin
         frame_tick = !frame_tick && ($urandom_range(0, 2) == 0);
         btn_start  = ($urandom_range(0, 9) == 0);
         btn_select = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 39) == 0) hp_zero = !hp_zero;
         score_in = SW'($urandom);
         rst_n = ($urandom_range(0, 3999) != 0);
         step();
      end
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
